shift: RTL and testbench
========================

// Module: shift
// PURPOSE
// - MIX shift execution unit (opcode 6): shifts rA, or the rA:rX pair, by M whole
//   MIX bytes (6 bits each, signs excluded).
// - Sits beside the ALU in the MIX CPU datapath. The sequencer pulses start with
//   register magnitudes, F field and effective address M, then writes out back to rA/rX.
// - Single-stage registered barrel shifter: one result per cycle, no busy state.
//
// PARAMETERS
// - none (byte = 6 bits, word magnitude = 5 bytes = 30 bits, fixed by MIX)
//
// PORTS
// clk    in   1   system clock, all state on rising edge
// rst    in   1   reset, asynchronous, active-high
// start  in   1   sample inputs and compute result this edge
// ina    in   30  rA magnitude; byte1 = ina[29:24] ... byte5 = ina[5:0]
// inx    in   30  rX magnitude, same byte order
// field  in   6   F field: 0 SLA, 1 SRA, 2 SLAX, 3 SRAX, 4 SLC, 5 SRC
// m      in   12  shift count in bytes, unsigned
// out    out  60  result: out[59:30] = new rA, out[29:0] = new rX
// done   out  1   result valid, 1-cycle pulse
//
// BEHAVIOUR
// - One clock; reset is asynchronous and active-high. Clock port clk, reset port rst.
// - rst high: out = 60'o0 and done = 0 immediately. Both hold until a start is sampled after reset release.
// - Latency: start sampled high at edge N -> out updated and done = 1 after edge N.
// - done falls after edge N+1 unless start is high again at N+1.
// - start may be high every cycle (full throughput). Each edge uses that edge's inputs only.
// - start low: out holds its last value; done = 0.
// - Inputs are not latched between start pulses. Only inputs present at the start edge matter.
// - Let A = ina and X = inx. AX = {A, X} is 10 bytes (60 bits).
// - SLA: A shifts left m bytes, zero fill. X passes unchanged.
//   - m >= 5 -> A = 0.
// - SRA: A shifts right m bytes, zero fill. X passes unchanged.
//   - m >= 5 -> A = 0.
// - SLAX / SRAX: AX shifts left / right m bytes as one 60-bit value, zero fill.
//   - m >= 10 -> AX = 0.
// - SLC / SRC: AX rotates left / right by (m mod 10) bytes.
//   - m = 0, 10, 20 ... -> unchanged.
//   - m = 4095 is valid (rotates by 5).
// - m = 0, any field -> out = {A, X}.
// - field 6..63 (undefined): out = {A, X} unchanged and done still pulses. No error output.
// - Arithmetic: shift distance in bits = 6 * (effective byte count).
//   - Compute it without truncation for every m up to 4095.
//   - The saturating compares (>=5, >=10) use the full 12-bit m.
// - Signs are not handled here; the caller keeps the rA and rX signs.
// - rst asserted in the same cycle as start: reset wins, and that start is discarded.
//
// TESTING
// - Common setup: A = 30'o0102030405, X = 30'o0607101112.
// - Reset: assert rst mid-run -> out = 0 and done = 0 at once. First start after release gives a valid result.
// - SLC m=1 -> out = {30'o0203040506, 30'o0710111201}, done = 1 one cycle after start.
// - SRC m=1 -> {30'o1201020304, 30'o0506071011}.
//   - SRC m=10 -> unchanged.
//   - SLC m=11 equals SLC m=1.
// - SLA m=2 -> {30'o0304050000, 30'o0607101112}.
//   - SLA m=5 and SRA m=4095 -> A = 0, X unchanged.
// - SRAX m=3 -> {30'o0000000102, 30'o0304050607}.
//   - SLAX m=10 -> all zero.
// - Throughput: start every other cycle with field=4 and m incrementing 0..4095.
//   - Each result must match a reference model of (m mod 10) left rotation.
//   - out must hold between results.
//   - Field 7 -> inputs pass through.

Source files
------------

// File: rtl/shift.sv
// ============================================================================
// Module  : shift
// Purpose : MIX byte-granular shift/rotate unit for rA and the rA:rX pair.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [29:0] ina,
  input  logic [29:0] inx,
  input  logic [5:0]  field,
  input  logic [11:0] m,
  output logic [59:0] out,
  output logic        done
);

  localparam logic [5:0] C_SLA  = 6'd0;
  localparam logic [5:0] C_SRA  = 6'd1;
  localparam logic [5:0] C_SLAX = 6'd2;
  localparam logic [5:0] C_SRAX = 6'd3;
  localparam logic [5:0] C_SLC  = 6'd4;
  localparam logic [5:0] C_SRC  = 6'd5;

  logic [59:0] ax;
  logic [3:0]  rot;
  logic [6:0]  sh_lin;
  logic [6:0]  sh_rot;
  logic        m_ge5;
  logic        m_ge10;
  logic [59:0] out_d, out_q;
  logic        done_d, done_q;

  assign ax     = {ina, inx};
  assign m_ge5  = (m >= 12'd5);
  assign m_ge10 = (m >= 12'd10);
  assign rot    = 4'(m % 12'd10);
  // m[3:0] is only consumed by linear shifts after the saturation compares,
  // so the byte count there is always below 10 and the bit distance fits.
  assign sh_lin = {3'b000, m[3:0]} * 7'd6;
  assign sh_rot = {3'b000, rot} * 7'd6;

  always_comb begin
    out_d  = out_q;
    done_d = 1'b0;
    if (start) begin
      done_d = 1'b1;
      out_d  = ax;
      unique case (field)
        C_SLA:  out_d = {(m_ge5 ? 30'd0 : (ina << sh_lin)), inx};
        C_SRA:  out_d = {(m_ge5 ? 30'd0 : (ina >> sh_lin)), inx};
        C_SLAX: out_d = m_ge10 ? 60'd0 : (ax << sh_lin);
        C_SRAX: out_d = m_ge10 ? 60'd0 : (ax >> sh_lin);
        // A 60-bit shift by 60 yields zero, so rot = 0 needs no special case.
        C_SLC:  out_d = (ax << sh_rot) | (ax >> (7'd60 - sh_rot));
        C_SRC:  out_d = (ax >> sh_rot) | (ax << (7'd60 - sh_rot));
        default: out_d = ax;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= 60'd0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      done_q <= done_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_shift.sv
// ============================================================================
// Module  : tb_shift
// Purpose : Directed self-checking bench for the MIX shift unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shift;

  logic        clk;
  logic        rst;
  logic        start;
  logic [29:0] ina;
  logic [29:0] inx;
  logic [5:0]  field;
  logic [11:0] m;
  logic [59:0] out;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [29:0] A = 30'o0102030405;
  localparam logic [29:0] X = 30'o0607101112;

  shift dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ina   (ina),
    .inx   (inx),
    .field (field),
    .m     (m),
    .out   (out),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [59:0] obs, input logic [59:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic s, input logic [5:0] f, input logic [11:0] mm,
                     input logic [29:0] a, input logic [29:0] x);
    start = s;
    field = f;
    m     = mm;
    ina   = a;
    inx   = x;
    @(posedge clk);
    #1;
  endtask

  // Byte-wise reference: result byte i takes source byte (i + r) mod 10.
  function automatic logic [59:0] rotl_ref(input logic [59:0] v, input int r);
    logic [5:0]  b [10];
    logic [59:0] res;
    res = '0;
    for (int i = 0; i < 10; i++) b[i] = v[59-6*i -: 6];
    for (int i = 0; i < 10; i++) res[59-6*i -: 6] = b[(i + r) % 10];
    return res;
  endfunction

  initial begin
    logic [59:0] held;
    logic [29:0] ra, rx;

    rst = 1'b1; start = 1'b0; field = '0; m = '0; ina = '0; inx = '0;
    #1;
    chk("reset_out", out, 60'd0);
    chk("reset_done", {59'd0, done}, 60'd0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 6'd4, 12'd1, A, X);
    chk("idle_after_reset_out", out, 60'd0);
    chk("idle_after_reset_done", {59'd0, done}, 60'd0);

    cyc(1'b1, 6'd4, 12'd1, A, X);
    chk("slc1", out, {30'o0203040506, 30'o0710111201});
    chk("slc1_done", {59'd0, done}, 60'd1);
    cyc(1'b0, 6'd0, 12'd0, 30'd0, 30'd0);
    chk("slc1_hold", out, {30'o0203040506, 30'o0710111201});
    chk("done_falls", {59'd0, done}, 60'd0);

    cyc(1'b1, 6'd5, 12'd1, A, X);
    chk("src1", out, {30'o1201020304, 30'o0506071011});
    cyc(1'b1, 6'd5, 12'd10, A, X);
    chk("src10", out, {A, X});
    chk("b2b_done", {59'd0, done}, 60'd1);
    cyc(1'b1, 6'd4, 12'd11, A, X);
    chk("slc11", out, {30'o0203040506, 30'o0710111201});
    cyc(1'b1, 6'd4, 12'd4095, A, X);
    chk("slc4095", out, {X, A});
    cyc(1'b1, 6'd5, 12'd4095, A, X);
    chk("src4095", out, {X, A});

    cyc(1'b1, 6'd0, 12'd2, A, X);
    chk("sla2", out, {30'o0304050000, X});
    cyc(1'b1, 6'd0, 12'd4, A, X);
    chk("sla4", out, {30'o0500000000, X});
    cyc(1'b1, 6'd0, 12'd5, A, X);
    chk("sla5", out, {30'd0, X});
    cyc(1'b1, 6'd1, 12'd2, A, X);
    chk("sra2", out, {30'o0000010203, X});
    cyc(1'b1, 6'd1, 12'd4095, A, X);
    chk("sra4095", out, {30'd0, X});
    cyc(1'b1, 6'd0, 12'd16, A, X);
    chk("sla16", out, {30'd0, X});

    cyc(1'b1, 6'd3, 12'd3, A, X);
    chk("srax3", out, {30'o0000000102, 30'o0304050607});
    cyc(1'b1, 6'd2, 12'd9, A, X);
    chk("slax9", out, {30'o1200000000, 30'd0});
    cyc(1'b1, 6'd3, 12'd9, A, X);
    chk("srax9", out, {30'd0, 30'o0000000001});
    cyc(1'b1, 6'd2, 12'd10, A, X);
    chk("slax10", out, 60'd0);
    cyc(1'b1, 6'd3, 12'd0, A, X);
    chk("srax0", out, {A, X});
    cyc(1'b1, 6'd2, 12'd26, A, X);
    chk("slax26", out, 60'd0);

    cyc(1'b1, 6'd7, 12'd3, A, X);
    chk("field7", out, {A, X});
    chk("field7_done", {59'd0, done}, 60'd1);
    cyc(1'b1, 6'd63, 12'd1, X, A);
    chk("field63", out, {X, A});

    // Asynchronous reset mid-cycle, then reset held across a start edge.
    cyc(1'b1, 6'd4, 12'd1, A, X);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out", out, 60'd0);
    chk("async_rst_done", {59'd0, done}, 60'd0);
    @(negedge clk);
    cyc(1'b1, 6'd4, 12'd1, A, X);
    chk("rst_beats_start_out", out, 60'd0);
    chk("rst_beats_start_done", {59'd0, done}, 60'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 6'd4, 12'd1, A, X);
    chk("post_rst_slc1", out, {30'o0203040506, 30'o0710111201});
    chk("post_rst_done", {59'd0, done}, 60'd1);

    // Sweep every m with SLC, idle cycle between with scrambled inputs.
    for (int k = 0; k < 4096; k++) begin
      ra = 30'($urandom);
      rx = 30'($urandom);
      cyc(1'b1, 6'd4, 12'(k), ra, rx);
      chk("sweep_slc", out, rotl_ref({ra, rx}, k % 10));
      chk("sweep_done", {59'd0, done}, 60'd1);
      held = out;
      cyc(1'b0, 6'($urandom), 12'($urandom), 30'($urandom), 30'($urandom));
      chk("sweep_hold", out, held);
      chk("sweep_idle_done", {59'd0, done}, 60'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
